// File: rtl/cart_bank_mapper.sv
// Cartridge ROM bank mapper: translates CPU ROM word addresses through a
// bank-page table and forwards reads to memory over a toggle handshake.
// Bank writes that arrive while a read is in flight are held in a 1-deep
// pending register and applied on the completion edge, so a transfer never
// sees a mixed mapping.
// Optional build macro MAPPER_BANK0_WR_EN: when defined, bank 0 is writable
// like any other bank; otherwise bank 0 is fixed at page 0.
module cart_bank_mapper #(
    parameter int NUM_BANKS = 8,
    parameter int BANK_BITS = 19,
    parameter int PAGE_W    = 6,
    localparam int SEL_W    = $clog2(NUM_BANKS)
) (
    input  logic                          MCLK,
    input  logic                          RESET_N,
    input  logic [SEL_W-1:0]              MAPPER_A,
    input  logic                          MAPPER_WE,
    input  logic [PAGE_W-1:0]             MAPPER_D,
    input  logic [PAGE_W-1:0]             PAGE_MASK,
    input  logic [BANK_BITS+SEL_W-1:1]    CPU_ADDR,
    input  logic                          CPU_REQ,
    output logic                          CPU_ACK,
    output logic [15:0]                   CPU_DOUT,
    output logic [PAGE_W+BANK_BITS-1:1]   MEM_ADDR,
    output logic                          MEM_REQ,
    input  logic                          MEM_ACK,
    input  logic [15:0]                   MEM_DIN,
    output logic                          USE_MAP,
    output logic                          BUSY
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                        state, state_nx;
    logic [PAGE_W-1:0]             page_tab [NUM_BANKS];
    logic                          pend_valid;
    logic [SEL_W-1:0]              pend_a;
    logic [PAGE_W-1:0]             pend_d;
    logic                          cpu_ack_q, mem_req_q, busy_q, use_map_q;
    logic [15:0]                   cpu_dout_q;
    logic [PAGE_W+BANK_BITS-1:1]   mem_addr_q;

    logic                          req_pending, mem_done, start, finish;
    logic                          wr_accept, wr_now, wr_defer;
    logic                          tab_we;
    logic [SEL_W-1:0]              tab_wa;
    logic [PAGE_W-1:0]             tab_wd;
    logic [SEL_W-1:0]              sel;
    logic [PAGE_W-1:0]             page;

    assign req_pending = CPU_REQ ^ cpu_ack_q;
    assign mem_done    = ~(MEM_ACK ^ mem_req_q);

`ifdef MAPPER_BANK0_WR_EN
    assign wr_accept = MAPPER_WE;
`else
    // Bank 0 keeps its reset page 0 forever, protecting the vector area.
    assign wr_accept = MAPPER_WE && (MAPPER_A != '0);
`endif

    // Writes land immediately only when idle and no request is being taken.
    assign wr_now   = wr_accept && (state == S_IDLE) && !req_pending;
    assign wr_defer = wr_accept && !wr_now;

    // Combinational translation; only the resulting address is registered.
    assign sel  = CPU_ADDR[BANK_BITS+SEL_W-1:BANK_BITS];
    assign page = page_tab[sel] & PAGE_MASK;

    // Next-state and handshake control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nx = state;
        start    = 1'b0;
        finish   = 1'b0;
        case (state)
            S_IDLE: if (req_pending) begin
                start    = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: if (mem_done) begin
                finish   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Table write port: a write arriving on the completion edge is the newest, so it beats the pending one.
    always_comb begin
        tab_we = 1'b0;
        tab_wa = MAPPER_A;
        tab_wd = MAPPER_D;
        if (wr_now || (finish && wr_accept)) begin
            tab_we = 1'b1;
        end else if (finish && pend_valid) begin
            tab_we = 1'b1;
            tab_wa = pend_a;
            tab_wd = pend_d;
        end
    end

    // State register.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Page table and mapping-status flag.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: the table is a handful of flops, so it is reset to identity rather than left uninitialised like a RAM.
            for (int i = 0; i < NUM_BANKS; i++) page_tab[i] <= PAGE_W'(i);
            use_map_q <= 1'b0;
        end else if (tab_we) begin
            page_tab[tab_wa] <= tab_wd;
            use_map_q        <= 1'b1;
        end
    end

    // One-deep pending bank write; last write wins, cleared when applied.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_valid <= 1'b0;
            pend_a     <= '0;
            pend_d     <= '0;
        end else if (finish) begin
            pend_valid <= 1'b0;
        end else if (wr_defer) begin
            pend_valid <= 1'b1;
            pend_a     <= MAPPER_A;
            pend_d     <= MAPPER_D;
        end
    end

    // Handshake datapath: launch on start, return data on finish.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cpu_dout_q <= '0;
            busy_q     <= 1'b0;
        end else if (start) begin
            mem_addr_q <= {page, CPU_ADDR[BANK_BITS-1:1]};
            mem_req_q  <= ~mem_req_q;
            busy_q     <= 1'b1;
        end else if (finish) begin
            cpu_dout_q <= MEM_DIN;
            cpu_ack_q  <= ~cpu_ack_q;
            busy_q     <= 1'b0;
        end
    end

    assign CPU_ACK  = cpu_ack_q;
    assign CPU_DOUT = cpu_dout_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_REQ  = mem_req_q;
    assign USE_MAP  = use_map_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Self-checking bench for cart_bank_mapper: directed scenarios followed by
// randomized reads and bank writes, checked against a page-table model.
module tb_cart_bank_mapper;

    localparam int LW = 18;                  // word bits inside one bank
    localparam int WMASK = (1 << 21) - 1;    // CPU word address range

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mapper_a;
    logic        mapper_we;
    logic [5:0]  mapper_d;
    logic [5:0]  page_mask;
    logic [21:1] cpu_addr;
    logic        cpu_req;
    logic        cpu_ack;
    logic [15:0] cpu_dout;
    logic [24:1] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_din;
    logic        use_map;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int  m_tab [8];
    bit  m_pend;
    int  m_pa, m_pd;
    bit  m_use;
    bit  exp_ack, exp_req;
    int  exp_ma;

    cart_bank_mapper dut (
        .MCLK(clk), .RESET_N(rst_n),
        .MAPPER_A(mapper_a), .MAPPER_WE(mapper_we), .MAPPER_D(mapper_d),
        .PAGE_MASK(page_mask),
        .CPU_ADDR(cpu_addr), .CPU_REQ(cpu_req), .CPU_ACK(cpu_ack), .CPU_DOUT(cpu_dout),
        .MEM_ADDR(mem_addr), .MEM_REQ(mem_req), .MEM_ACK(mem_ack), .MEM_DIN(mem_din),
        .USE_MAP(use_map), .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tab[i] = i;
        m_pend  = 0;
        m_use   = 0;
        exp_ack = 0;
        exp_req = 0;
    endtask

    function automatic bit bank_writable(input int a);
`ifdef MAPPER_BANK0_WR_EN
        return 1'b1;
`else
        return a != 0;
`endif
    endfunction

    task automatic model_write(input int a, input int d, input bit inflight);
        if (bank_writable(a)) begin
            if (inflight) begin
                m_pend = 1; m_pa = a; m_pd = d;
            end else begin
                m_tab[a] = d; m_use = 1;
            end
        end
    endtask

    task automatic model_complete();
        if (m_pend) begin
            m_tab[m_pa] = m_pd;
            m_use  = 1;
            m_pend = 0;
        end
    endtask

    function automatic int model_addr(input int word);
        int page;
        page = m_tab[(word >> LW) & 7] & int'(page_mask);
        return (page << LW) | (word & ((1 << LW) - 1));
    endfunction

    // One-cycle bank write pulse.
    task automatic wr_cycle(input int a, input int d, input bit inflight);
        mapper_a  = 3'(a);
        mapper_d  = 6'(d);
        mapper_we = 1'b1;
        @(posedge clk); #1;
        mapper_we = 1'b0;
        model_write(a, d, inflight);
    endtask

    task automatic do_write(input int a, input int d);
        wr_cycle(a, d, 0);
        check("use_map_after_write", use_map, m_use);
    endtask

    // Toggle CPU_REQ (optionally with a same-cycle bank write) and check launch.
    task automatic start_read(input int word, input bit same_wr, input int a, input int d);
        cpu_addr = 21'(word);
        cpu_req  = ~cpu_req;
        exp_ma   = model_addr(word);
        if (same_wr) begin
            mapper_a = 3'(a); mapper_d = 6'(d); mapper_we = 1'b1;
        end
        @(posedge clk); #1;
        mapper_we = 1'b0;
        if (same_wr) model_write(a, d, 1);
        exp_req = ~exp_req;
        check("mem_req_toggle", mem_req, exp_req);
        check("mem_addr_launch", mem_addr, exp_ma);
        check("busy_launch", busy, 1);
        check("cpu_ack_hold", cpu_ack, exp_ack);
    endtask

    // Memory answers after lat cycles; optional random bank writes meanwhile.
    task automatic finish_read(input int lat, input logic [15:0] data, input bit rnd_wr);
        for (int i = 0; i < lat; i++) begin
            if (rnd_wr && ($urandom_range(0, 2) == 0)) begin
                wr_cycle($urandom_range(0, 7), $urandom_range(0, 63), 1);
            end else begin
                @(posedge clk); #1;
            end
            check("mem_addr_stable", mem_addr, exp_ma);
            check("busy_wait", busy, 1);
            check("cpu_ack_wait", cpu_ack, exp_ack);
        end
        mem_din = data;
        mem_ack = ~mem_ack;
        @(posedge clk); #1;
        exp_ack = ~exp_ack;
        model_complete();
        check("cpu_ack_toggle", cpu_ack, exp_ack);
        check("cpu_dout", cpu_dout, data);
        check("busy_done", busy, 0);
        check("use_map_done", use_map, m_use);
    endtask

    initial begin
        rst_n = 1'b0; mapper_a = '0; mapper_we = 1'b0; mapper_d = '0;
        page_mask = 6'h3F; cpu_addr = '0; cpu_req = 1'b0;
        mem_ack = 1'b0; mem_din = '0;
        model_reset();
        #1;
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_use_map", use_map, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity mapping before any bank write.
        start_read('h0C0002, 0, 0, 0);
        check("identity_addr", mem_addr, 'h0C0002);
        finish_read(5, 16'hBEEF, 0);
        check("identity_use_map", use_map, 0);

        // Idle bank write takes effect immediately.
        do_write(3, 'h2A);
        start_read('h0C0004, 0, 0, 0);
        check("bank3_2a_addr", mem_addr, 'hA80004);
        finish_read(1, 16'h1234, 0);
        check("bank3_use_map", use_map, 1);

        // Writes during WAIT are deferred; last one wins.
        start_read('h0C0008, 0, 0, 0);
        wr_cycle(3, 'h11, 1);
        wr_cycle(3, 'h12, 1);
        check("inflight_old_page", mem_addr, 'hA80008);
        finish_read(2, 16'h5A5A, 0);
        start_read('h0C0000, 0, 0, 0);
        check("deferred_page_12", mem_addr, 'h480000);
        finish_read(0, 16'h0F0F, 0);

        // Bank 0 write.
        do_write(0, 5);
        start_read('h000010, 0, 0, 0);
`ifdef MAPPER_BANK0_WR_EN
        check("bank0_page", mem_addr, 'h140010);
`else
        check("bank0_page", mem_addr, 'h000010);
`endif
        finish_read(1, 16'h0000, 0);

        // Page mask wrap.
        page_mask = 6'h0F;
        do_write(2, 'h23);
        start_read('h080006, 0, 0, 0);
        check("mask_wrap", mem_addr, 'h0C0006);
        finish_read(3, 16'hFFFF, 0);
        page_mask = 6'h3F;

        // Write in the same cycle a request is detected uses the old mapping.
        start_read('h0C0000, 1, 3, 'h07);
        check("same_cycle_old", mem_addr, 'h480000);
        finish_read(1, 16'hC0DE, 0);
        start_read('h0C0000, 0, 0, 0);
        check("same_cycle_new", mem_addr, 'h1C0000);
        finish_read(0, 16'hD00D, 0);

        // Randomized reads and writes against the model.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_write($urandom_range(0, 7), $urandom_range(0, 63));
            end else begin
                case ($urandom_range(0, 3))
                    0: page_mask = 6'h3F;
                    1: page_mask = 6'h1F;
                    2: page_mask = 6'h0F;
                    default: page_mask = 6'h07;
                endcase
                start_read(int'($urandom) & WMASK, ($urandom_range(0, 3) == 0),
                           $urandom_range(0, 7), $urandom_range(0, 63));
                finish_read($urandom_range(0, 4), 16'($urandom), 1);
            end
        end

        // Reset during WAIT abandons the transfer and restores identity.
        page_mask = 6'h3F;
        start_read('h0C0020, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_cpu_ack", cpu_ack, 0);
        check("midrst_busy", busy, 0);
        check("midrst_use_map", use_map, 0);
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_read('h0C0010, 0, 0, 0);
        check("post_rst_identity", mem_addr, 'h0C0010);
        finish_read(2, 16'hAAAA, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
